// File: rtl/btn_events.sv
// btn_events: per-button synchroniser, debouncer and press/release/long-press classifier.
// Define BTN_AUTOREPEAT_EN to emit repeating press pulses while a button is held past the long-press time.
module btn_events #(
    parameter int NUM_BTN         = 3,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int LONG_CYCLES     = 100_000_000,
    parameter int REPEAT_CYCLES   = 25_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] press_pulse,
    output logic [NUM_BTN-1:0] release_pulse,
    output logic [NUM_BTN-1:0] long_pulse
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
`ifdef BTN_AUTOREPEAT_EN
    localparam int HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
`else
    localparam int HOLD_MAX = LONG_CYCLES;
`endif
    localparam int HOLD_W = $clog2(HOLD_MAX);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYCLES - 1);
`ifdef BTN_AUTOREPEAT_EN
    localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CYCLES - 1);
`endif

    if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES <= DEBOUNCE_CYCLES || REPEAT_CYCLES < 1) begin : g_bad_params
        $error("btn_events: illegal timing parameters");
    end

    typedef enum logic [1:0] {
        ST_RELEASED,
        ST_HELD,
        ST_LONG
    } st_t;

    logic [NUM_BTN-1:0] s1;
    logic [NUM_BTN-1:0] s2;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= btn_raw;
            s2 <= s1;
        end
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        logic [DB_W-1:0]   db_cnt;
        logic              level_q;
        logic              flip;
        logic              rise;
        logic              fall;
        st_t               st;
        st_t               st_nxt;
        logic [HOLD_W-1:0] hold_cnt;
        logic [HOLD_W-1:0] hold_nxt;
        logic              press_q;
        logic              release_q;
        logic              long_q;
        logic              press_nxt;
        logic              release_nxt;
        logic              long_nxt;

        // The level flips on the edge where the disagreement has lasted DEBOUNCE_CYCLES cycles.
        assign flip = (s2[i] != level_q) && (db_cnt == DB_LAST);
        assign rise = flip & s2[i];
        assign fall = flip & ~s2[i];

        always_ff @(posedge clk) begin
            if (!rst) begin
                db_cnt  <= '0;
                level_q <= 1'b0;
            end else if (s2[i] == level_q || flip) begin
                db_cnt <= '0;
                if (flip) begin
                    level_q <= s2[i];
                end
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end

        always_comb begin
            st_nxt      = st;
            hold_nxt    = hold_cnt;
            press_nxt   = 1'b0;
            release_nxt = 1'b0;
            long_nxt    = 1'b0;
            case (st)
                ST_RELEASED: begin
                    if (rise) begin
                        st_nxt    = ST_HELD;
                        press_nxt = 1'b1;
                        hold_nxt  = '0;
                    end
                end
                ST_HELD: begin
                    if (fall) begin
                        st_nxt      = ST_RELEASED;
                        release_nxt = 1'b1;
                    end else if (hold_cnt == LONG_LAST) begin
                        st_nxt   = ST_LONG;
                        long_nxt = 1'b1;
                        hold_nxt = '0;
                    end else begin
                        hold_nxt = hold_cnt + HOLD_W'(1);
                    end
                end
                ST_LONG: begin
                    // A release wins over a repeat expiry landing on the same cycle.
                    if (fall) begin
                        st_nxt      = ST_RELEASED;
                        release_nxt = 1'b1;
                    end
`ifdef BTN_AUTOREPEAT_EN
                    else if (hold_cnt == REP_LAST) begin
                        press_nxt = 1'b1;
                        hold_nxt  = '0;
                    end else begin
                        hold_nxt = hold_cnt + HOLD_W'(1);
                    end
`endif
                end
                default: begin
                    st_nxt = ST_RELEASED;
                end
            endcase
        end

        always_ff @(posedge clk) begin
            if (!rst) begin
                st        <= ST_RELEASED;
                hold_cnt  <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
            end else begin
                st        <= st_nxt;
                hold_cnt  <= hold_nxt;
                press_q   <= press_nxt;
                release_q <= release_nxt;
                long_q    <= long_nxt;
            end
        end

        assign btn_level[i]     = level_q;
        assign press_pulse[i]   = press_q;
        assign release_pulse[i] = release_q;
        assign long_pulse[i]    = long_q;
    end

endmodule

// File: tb/tb_btn_events.sv
// Directed bench for btn_events with short timing parameters (debounce 4, long 20, repeat 8).
module tb_btn_events;

    logic       clk;
    logic       rst;
    logic [2:0] btn_raw;
    logic [2:0] btn_level;
    logic [2:0] press_pulse;
    logic [2:0] release_pulse;
    logic [2:0] long_pulse;

    int n_checks;
    int n_errors;
    int cyc;
    int t;
    int press_cnt[3];
    int rel_cnt[3];
    int long_cnt[3];
    int last_press[3];
    int last_rel[3];
    int last_long[3];
    int ptimes[$];

    btn_events #(
        .NUM_BTN(3),
        .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES(20),
        .REPEAT_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_raw(btn_raw),
        .btn_level(btn_level),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse),
        .long_pulse(long_pulse)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Event logger: stamps every pulse with the index of the edge that produced it.
    always @(posedge clk) begin
        #2;
        cyc++;
        for (int i = 0; i < 3; i++) begin
            if (press_pulse[i] === 1'b1) begin
                press_cnt[i]++;
                last_press[i] = cyc;
                if (i == 0) ptimes.push_back(cyc);
            end
            if (release_pulse[i] === 1'b1) begin
                rel_cnt[i]++;
                last_rel[i] = cyc;
            end
            if (long_pulse[i] === 1'b1) begin
                long_cnt[i]++;
                last_long[i] = cyc;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clr();
        for (int i = 0; i < 3; i++) begin
            press_cnt[i]  = 0;
            rel_cnt[i]    = 0;
            long_cnt[i]   = 0;
            last_press[i] = -1;
            last_rel[i]   = -1;
            last_long[i]  = -1;
        end
        ptimes.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        clr();
        rst     = 1'b0;
        btn_raw = 3'b111;

        // Reset with all buttons held.
        tick(10);
        check("rst_level", btn_level, 3'b000);
        check("rst_press", press_pulse, 3'b000);
        check("rst_release", release_pulse, 3'b000);
        check("rst_long", long_pulse, 3'b000);
        clr();
        rst = 1'b1;
        t   = cyc;
        tick(5);
        check("post_rst_level_early", btn_level, 3'b000);
        tick(1);
        check("post_rst_level", btn_level, 3'b111);
        check("post_rst_press", press_pulse, 3'b111);
        check("post_rst_press_time", last_press[2], t + 6);
        tick(1);
        check("post_rst_press_width", press_pulse, 3'b000);
        btn_raw = 3'b000;
        tick(8);
        check("post_rst_released", btn_level, 3'b000);
        check("post_rst_rel_cnt", rel_cnt[0] + rel_cnt[1] + rel_cnt[2], 3);

        // Clean press and release on bit 1.
        clr();
        btn_raw = 3'b010;
        t = cyc;
        tick(5);
        check("clean_level_early", btn_level[1], 1'b0);
        tick(1);
        check("clean_level", btn_level, 3'b010);
        check("clean_press", press_pulse, 3'b010);
        check("clean_press_time", last_press[1], t + 6);
        tick(1);
        check("clean_press_width", press_pulse, 3'b000);
        tick(8);
        btn_raw = 3'b000;
        t = cyc;
        tick(6);
        check("clean_release", release_pulse, 3'b010);
        check("clean_release_time", last_rel[1], t + 6);
        check("clean_level_low", btn_level, 3'b000);
        tick(2);
        check("clean_no_long", long_cnt[1], 0);
        check("clean_press_cnt", press_cnt[1], 1);

        // Bounce 1,0,1,0 then steady 1 on bit 1.
        clr();
        btn_raw = 3'b010; tick(1);
        btn_raw = 3'b000; tick(1);
        btn_raw = 3'b010; tick(1);
        btn_raw = 3'b000; tick(1);
        btn_raw = 3'b010;
        t = cyc;
        tick(5);
        check("bounce_no_early_press", press_cnt[1], 0);
        tick(1);
        check("bounce_press", press_pulse, 3'b010);
        check("bounce_press_time", last_press[1], t + 6);
        check("bounce_no_release", rel_cnt[1], 0);
        tick(2);
        check("bounce_press_cnt", press_cnt[1], 1);
        btn_raw = 3'b000;
        tick(8);
        check("bounce_release_cnt", rel_cnt[1], 1);

`ifndef BTN_AUTOREPEAT_EN
        // Long press on bit 0, silent in LONG.
        clr();
        btn_raw = 3'b001;
        t = cyc;
        tick(40);
        check("long_cnt", long_cnt[0], 1);
        check("long_press_time", last_press[0], t + 6);
        check("long_delay", last_long[0] - last_press[0], 20);
        check("long_no_repeat", press_cnt[0], 1);
        check("long_no_release", rel_cnt[0], 0);
        btn_raw = 3'b000;
        tick(8);
        check("long_release_cnt", rel_cnt[0], 1);
        check("long_cnt_after", long_cnt[0], 1);
`else
        // Auto-repeat on bit 0; the release lands on a repeat expiry.
        clr();
        btn_raw = 3'b001;
        t = cyc;
        tick(60);
        btn_raw = 3'b000;
        tick(10);
        check("ar_long_time", last_long[0], t + 26);
        check("ar_press_cnt", ptimes.size(), 5);
        check("ar_repeat1", ptimes[1], last_long[0] + 8);
        check("ar_repeat2", ptimes[2], last_long[0] + 16);
        check("ar_last_press", last_press[0], t + 58);
        check("ar_release_time", last_rel[0], t + 66);
        check("ar_long_cnt", long_cnt[0], 1);
`endif

        // Independent channels: bit 0 then bit 2 two cycles later.
        clr();
        btn_raw = 3'b001;
        t = cyc;
        tick(2);
        btn_raw = 3'b101;
        tick(8);
        check("ind_press0_time", last_press[0], t + 6);
        check("ind_press_offset", last_press[2] - last_press[0], 2);
        btn_raw = 3'b100;
        tick(2);
        btn_raw = 3'b000;
        tick(8);
        check("ind_release_offset", last_rel[2] - last_rel[0], 2);
        check("ind_bit1_press", press_cnt[1], 0);
        check("ind_bit1_release", rel_cnt[1], 0);
        check("ind_no_long", long_cnt[0] + long_cnt[2], 0);
        check("ind_level", btn_level, 3'b000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/btn_events.md
# btn_events

Per-button input conditioner generating the clean button levels and single-cycle event pulses consumed by `blinker`. Takes raw, asynchronous, bouncy push-button inputs (`sw_btn`, `left_btn`, `right_btn` at the top level). Synchronises, debounces and classifies each one into press, release and long-press events. Sits between the board pins and `blinker`, on the same single fabric clock as `blinker`.

## Interface
- `NUM_BTN`, 3: number of independent button channels. Bit 0 = sw, 1 = left, 2 = right.
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive cycles a synchronised input must differ from the stable level before the level flips. Minimum 2.
- `LONG_CYCLES`, 100_000_000: cycles after a press before a long-press event. Must be > `DEBOUNCE_CYCLES`.
- `REPEAT_CYCLES`, 25_000_000: auto-repeat interval (only with `BTN_AUTOREPEAT_EN`).
- `clk` in 1: fabric clock, single clock domain.
- `rst` in 1: synchronous, active-low reset.
- `btn_raw` in NUM_BTN: raw button pins, active-high, asynchronous.
- `btn_level` out NUM_BTN: debounced stable level.
- `press_pulse` out NUM_BTN: 1-cycle pulse on debounced press (and on each auto-repeat).
- `release_pulse` out NUM_BTN: 1-cycle pulse on debounced release.
- `long_pulse` out NUM_BTN: 1-cycle pulse when held for `LONG_CYCLES`.

## Operation
- Each channel is independent, with identical logic replicated `NUM_BTN` times.
- Synchroniser: 2-FF chain per bit (`s1`, `s2`). No logic between the flops.
- Debounce counter, width `$clog2(DEBOUNCE_CYCLES)`:
  - Clears whenever `s2 == btn_level`.
  - Increments while `s2 != btn_level`.
  - When the count is `DEBOUNCE_CYCLES-1` and `s2` still differs, `btn_level` toggles and the counter clears.
  - Any bounce back to the stable value restarts the count from 0.
- Per-channel FSM, state register `st`:
  - RELEASED: `btn_level`=0. On debounced rise → HELD, `press_pulse`=1, hold counter cleared.
  - HELD: hold counter increments each cycle.
    - Count reaches `LONG_CYCLES-1` → LONG, `long_pulse`=1, hold counter cleared.
    - Debounced fall → RELEASED, `release_pulse`=1.
  - LONG: debounced fall → RELEASED, `release_pulse`=1.
    - With `BTN_AUTOREPEAT_EN`: hold counter counts, and each time it reaches `REPEAT_CYCLES-1` it emits `press_pulse` and clears.
- Hold counter width: `$clog2(max(LONG_CYCLES, REPEAT_CYCLES))`. It saturates (never wraps) in LONG when auto-repeat is disabled.
- A release takes priority over a same-cycle long/repeat expiry: only `release_pulse` fires.
- Reset: `s1`, `s2`, `btn_level`, all counters and all pulses = 0; `st` = RELEASED. A button held through reset deassertion is treated as a fresh press after full debounce. No event is emitted for the pre-reset state.

## Timing
- All outputs are registered. Pulses are exactly 1 cycle wide and never back-to-back on the same channel.
- Latency: raw edge first sampled at clock edge E → `s2` reflects it at E+1 → `btn_level` flips at E+1+`DEBOUNCE_CYCLES`.
- `press_pulse`/`release_pulse` are high in the same cycle `btn_level` first shows its new value.
- `long_pulse` is high in the cycle exactly `LONG_CYCLES` after the `press_pulse` cycle.
- Auto-repeat `press_pulse` fires every `REPEAT_CYCLES` cycles after the `long_pulse` cycle.
- Minimum debounced high or low width: `DEBOUNCE_CYCLES` cycles.

## Configuration
- `BTN_AUTOREPEAT_EN` defined:
  - LONG state emits a periodic `press_pulse` every `REPEAT_CYCLES` until release.
  - `REPEAT_CYCLES` is used.
- `BTN_AUTOREPEAT_EN` undefined:
  - No repeat logic; `REPEAT_CYCLES` is ignored.
  - LONG is silent until release.
  - The hold counter stops at LONG entry.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `LONG_CYCLES`=20, `REPEAT_CYCLES`=8, `NUM_BTN`=3.
- Reset: hold `rst`=0 for 10 cycles with `btn_raw`=3'b111 → all outputs 0. After release, `btn_level`=3'b111 exactly 5 cycles after the first post-reset edge, with `press_pulse`=3'b111 for one cycle.
- Clean press/release on bit 1: `btn_level[1]` rises 5 cycles after the raw edge, with a 1-cycle `press_pulse[1]`. After a 10-cycle hold and raw release, `release_pulse[1]` fires 5 cycles later. `long_pulse` stays 0.
- Bounce: raw toggles 1,0,1,0 on consecutive cycles then stays 1 → exactly one `press_pulse`, 5 cycles after the final rising edge. No `release_pulse`.
- Long press, no auto-repeat: hold 40 cycles → `long_pulse[0]` exactly 20 cycles after `press_pulse[0]`, no further pulses until release.
- Auto-repeat (`BTN_AUTOREPEAT_EN`): hold 60 cycles → `press_pulse` at the long+8 and long+16 cycles. A release on a repeat-expiry cycle yields only `release_pulse`.
- Independence: simultaneous presses on bits 0 and 2 offset by 2 cycles → pulses are offset by exactly 2 cycles, and bit 1 stays silent.
